// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V front-end definitions used by the IF/ID boundary, the opcode
// classifier and the immediate-path logic and benches.
//
// Contents:
//   RV_XLEN          default data/PC width
//   OPC_*            7-bit major opcodes (instruction bits [6:0])
//   rv_fmt_flags_t   one-hot instruction format flags (I/S/B/U/J/R)
//   rv_entry_t       one buffered IF/ID entry: word, PC, flags, illegal bit
//   fmt_flags_none() true when a flag set carries no format
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int RV_XLEN = 32;

    // Major opcodes, grouped by the immediate format they use.
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic is_i;
        logic is_s;
        logic is_b;
        logic is_u;
        logic is_j;
        logic is_r;
    } rv_fmt_flags_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] instruction;
        logic [RV_XLEN-1:0] pc;
        rv_fmt_flags_t      flags;
        logic               illegal;
    } rv_entry_t;

    function automatic logic fmt_flags_none(input rv_fmt_flags_t f);
        return (f == '0);
    endfunction

endpackage

// File: rtl/rv_opcode_classify.sv
// ----------------------------------------------------------------------------
// rv_opcode_classify
// Pure combinational opcode-to-format classifier. Maps instruction bits [6:0]
// onto one-hot I/S/B/U/J/R flags; unknown opcodes produce no flag at all.
//
// Parameters:
//   ILLEGAL_EN  1: drive 'illegal' for unmapped or non-32-bit encodings
//               0: 'illegal' is constant 0
// Ports:
//   opcode   in   7   instruction bits [6:0]
//   flags    out  6   one-hot format flags (all zero when unmapped)
//   illegal  out  1   unknown opcode / bad length bits (ILLEGAL_EN only)
// ----------------------------------------------------------------------------
module rv_opcode_classify
    import rv_pkg::*;
#(
    parameter bit ILLEGAL_EN = 1'b0
) (
    input  logic [6:0]    opcode,
    output rv_fmt_flags_t flags,
    output logic          illegal
);

    logic unmapped;

    always_comb begin
        flags    = '0;
        unmapped = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
                flags.is_i = 1'b1;
            OPC_STORE:
                flags.is_s = 1'b1;
            OPC_BRANCH:
                flags.is_b = 1'b1;
            OPC_LUI, OPC_AUIPC:
                flags.is_u = 1'b1;
            OPC_JAL:
                flags.is_j = 1'b1;
            OPC_OP:
                flags.is_r = 1'b1;
            default:
                unmapped = 1'b1;
        endcase
    end

    // Every mapped opcode already ends in 2'b11; the length-bit test is kept
    // explicit so compressed encodings stay illegal if the map ever grows.
    always_comb begin
        illegal = ILLEGAL_EN && (unmapped || (opcode[1:0] != 2'b11));
    end

endmodule

// File: rtl/rv_decode_stage.sv
// ----------------------------------------------------------------------------
// rv_decode_stage
// Registered IF/ID boundary in front of the immediate generator. Fetched words
// are classified on the way in and stored with their flags, so every output is
// driven straight from a register. A second (skid) entry absorbs the word that
// arrives while the main entry is stalled, which lets in_ready come from a
// flop instead of from out_ready.
//
// Build option:
//   ILLEGAL_CHECK_EN  defined: 'illegal' flags unmapped / non-32-bit words
//                     undefined: 'illegal' is constant 0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of both entries (branch redirect)
//   in_valid/ready    fetch-side handshake
//   in_instruction    fetched word
//   in_pc             PC of fetched word
//   out_valid/ready   decode-side handshake
//   out_instruction   registered instruction
//   out_pc            registered PC
//   is_type_*         registered one-hot format flags
//   illegal           registered illegal-opcode flag
// ----------------------------------------------------------------------------
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic            is_type_I,
    output logic            is_type_S,
    output logic            is_type_B,
    output logic            is_type_U,
    output logic            is_type_J,
    output logic            is_type_R,
    output logic            illegal
);

`ifdef ILLEGAL_CHECK_EN
    localparam bit ILLEGAL_EN = 1'b1;
`else
    localparam bit ILLEGAL_EN = 1'b0;
`endif

    rv_entry_t     main_q, main_d;
    rv_entry_t     skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    rv_entry_t     in_entry;
    rv_fmt_flags_t in_flags;
    logic          in_illegal;
    logic          accept;
    logic          fire;

    rv_opcode_classify #(
        .ILLEGAL_EN (ILLEGAL_EN)
    ) u_classify (
        .opcode  (in_instruction[6:0]),
        .flags   (in_flags),
        .illegal (in_illegal)
    );

    always_comb begin
        in_entry.instruction = in_instruction;
        in_entry.pc          = in_pc;
        in_entry.flags       = in_flags;
        in_entry.illegal     = in_illegal;
    end

    // Ready depends only on the skid flop: with the skid free there is always
    // room for one more word, whatever the back end does this cycle.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign fire     = main_valid_q && out_ready;

    // Entry routing. The skid only fills while main is stalled, and it always
    // drains into main before anything newer, which keeps acceptance order.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no accept can race the drain.
            if (fire) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || fire) begin
            main_valid_d = accept;
            if (accept) begin
                main_d = in_entry;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid       = main_valid_q;
    assign out_instruction = main_q.instruction;
    assign out_pc          = main_q.pc;
    assign is_type_I       = main_q.flags.is_i;
    assign is_type_S       = main_q.flags.is_s;
    assign is_type_B       = main_q.flags.is_b;
    assign is_type_U       = main_q.flags.is_u;
    assign is_type_J       = main_q.flags.is_j;
    assign is_type_R       = main_q.flags.is_r;
    assign illegal         = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_rv_decode_stage
// Directed and randomised bench for rv_decode_stage: format decode, streaming
// latency, skid backpressure, flush, asynchronous reset, the optional illegal
// flag (ILLEGAL_CHECK_EN) and a long random handshake run against a queue model.
// ----------------------------------------------------------------------------
module tb_rv_decode_stage;

`ifdef ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        is_type_I, is_type_S, is_type_B, is_type_U, is_type_J, is_type_R;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    rv_decode_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .is_type_I       (is_type_I),
        .is_type_S       (is_type_S),
        .is_type_B       (is_type_B),
        .is_type_U       (is_type_U),
        .is_type_J       (is_type_J),
        .is_type_R       (is_type_R),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] flags_now();
        return {is_type_I, is_type_S, is_type_B, is_type_U, is_type_J, is_type_R};
    endfunction

    // Reference decode, {I,S,B,U,J,R,unmapped}, written from the opcode table.
    function automatic logic [6:0] ref_decode(input logic [31:0] w);
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 7'b1000000;
            7'h23:                             return 7'b0100000;
            7'h63:                             return 7'b0010000;
            7'h37, 7'h17:                      return 7'b0001000;
            7'h6F:                             return 7'b0000100;
            7'h33:                             return 7'b0000010;
            default:                           return 7'b0000001;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instruction = '0; in_pc = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (flags_now() !== 6'b0 || illegal !== 1'b0) begin errors++;
            $display("[TB] FAIL reset_flags got %b/%b want 000000/0", flags_now(), illegal); end
        checks++; if (out_instruction !== 32'h0 || out_pc !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_data got %h/%h want 0/0", out_instruction, out_pc); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        logic [31:0] words [6];
        logic [5:0]  exp_f [6];
        words = '{32'h00500093, 32'h00112023, 32'h00208463,
                  32'h123450B7, 32'h008000EF, 32'h002081B3};
        exp_f = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instruction = words[i]; in_pc = 32'h100 + 32'(4 * i);
            checks++; if (in_ready !== 1'b1) begin errors++;
                $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_instruction !== words[i]) begin errors++;
                $display("[TB] FAIL stream_word[%0d] got v=%b %h want v=1 %h",
                         i, out_valid, out_instruction, words[i]); end
            checks++; if (out_pc !== 32'h100 + 32'(4 * i)) begin errors++;
                $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, out_pc, 32'h100 + 32'(4 * i)); end
            checks++; if (flags_now() !== exp_f[i] || illegal !== 1'b0) begin errors++;
                $display("[TB] FAIL stream_flags[%0d] got %b/%b want %b/0",
                         i, flags_now(), illegal, exp_f[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00112023; in_pc = 32'h200;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instruction !== 32'h00112023) begin errors++;
            $display("[TB] FAIL bp_first got v=%b r=%b %h want v=1 r=1 00112023",
                     out_valid, in_ready, out_instruction); end
        in_instruction = 32'h00208463; in_pc = 32'h204;
        step();
        checks++; if (in_ready !== 1'b0 || out_instruction !== 32'h00112023) begin errors++;
            $display("[TB] FAIL bp_skid_full got r=%b %h want r=0 00112023", in_ready, out_instruction); end
        in_instruction = 32'h123450B7; in_pc = 32'h208;
        step();
        checks++; if (in_ready !== 1'b0 || out_instruction !== 32'h00112023 || out_pc !== 32'h200
                     || flags_now() !== 6'b010000) begin errors++;
            $display("[TB] FAIL bp_hold got r=%b %h %h %b want r=0 00112023 200 010000",
                     in_ready, out_instruction, out_pc, flags_now()); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h00208463 || out_pc !== 32'h204
                     || in_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL bp_release1 got v=%b %h %h r=%b want v=1 00208463 204 r=1",
                     out_valid, out_instruction, out_pc, in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h123450B7 || flags_now() !== 6'b000100) begin errors++;
            $display("[TB] FAIL bp_release2 got v=%b %h %b want v=1 123450b7 000100",
                     out_valid, out_instruction, flags_now()); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h300;
        step();
        in_instruction = 32'h00112023; in_pc = 32'h304;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("[TB] FAIL flush_prefill got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
        in_instruction = 32'h008000EF; in_pc = 32'h308; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("[TB] FAIL flush_no_leak[%0d] got v=%b %h want v=0", i, out_valid, out_instruction); end
        end
        in_valid = 1'b1; in_instruction = 32'h002081B3; in_pc = 32'h30C; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL flush_drop_accept got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instruction = 32'h002081B3; in_pc = 32'h400;
        step();
        in_instruction = 32'h00500093; in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL async_reset_valid got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        checks++; if (flags_now() !== 6'b0 || illegal !== 1'b0) begin errors++;
            $display("[TB] FAIL async_reset_flags got %b/%b want 000000/0", flags_now(), illegal); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL post_reset_valid got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instruction = 32'h00000000; in_pc = 32'h500;
        step();
        checks++; if (out_valid !== 1'b1 || illegal !== ILL_EN || flags_now() !== 6'b0) begin errors++;
            $display("[TB] FAIL illegal_zero got v=%b ill=%b f=%b want v=1 ill=%b f=000000",
                     out_valid, illegal, flags_now(), ILL_EN); end
        in_instruction = 32'h0000007F; in_pc = 32'h504;
        step();
        checks++; if (out_valid !== 1'b1 || illegal !== ILL_EN || flags_now() !== 6'b0) begin errors++;
            $display("[TB] FAIL illegal_7f got v=%b ill=%b f=%b want v=1 ill=%b f=000000",
                     out_valid, illegal, flags_now(), ILL_EN); end
        in_instruction = 32'h00208463; in_pc = 32'h508;
        step();
        checks++; if (illegal !== 1'b0 || flags_now() !== 6'b001000) begin errors++;
            $display("[TB] FAIL illegal_legal got ill=%b f=%b want ill=0 f=001000", illegal, flags_now()); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [63:0] q [$];
        logic [6:0]  opcs [11];
        logic [31:0] w;
        logic [31:0] pc_ctr;
        logic [6:0]  rd;
        logic [31:0] h_instr, h_pc;
        logic [5:0]  h_flags;
        logic        h_ill;
        logic        stalled, acc, fr;
        int          occ;
        opcs = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        flush = 1'b0;
        occ = 0; pc_ctr = 32'h1000;
        h_instr = '0; h_pc = '0; h_flags = '0; h_ill = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
            in_instruction = w; in_pc = pc_ctr;
            acc = in_valid && (occ < 2);
            fr  = (occ > 0) && out_ready;
            checks++; if (in_ready !== (occ < 2) || out_valid !== (occ > 0)) begin errors++;
                $display("[TB] FAIL rand_hs[%0d] got v=%b r=%b want v=%b r=%b",
                         c, out_valid, in_ready, occ > 0, occ < 2); end
            if (occ > 0) begin
                rd = ref_decode(q[0][63:32]);
                checks++; if (out_instruction !== q[0][63:32] || out_pc !== q[0][31:0]) begin errors++;
                    $display("[TB] FAIL rand_order[%0d] got %h/%h want %h/%h",
                             c, out_instruction, out_pc, q[0][63:32], q[0][31:0]); end
                checks++; if (flags_now() !== rd[6:1] || illegal !== (ILL_EN & rd[0])) begin errors++;
                    $display("[TB] FAIL rand_flags[%0d] got %b/%b want %b/%b",
                             c, flags_now(), illegal, rd[6:1], ILL_EN & rd[0]); end
                checks++; if ($countones(flags_now()) > 1) begin errors++;
                    $display("[TB] FAIL rand_onehot[%0d] got %b want at most one bit", c, flags_now()); end
            end
            stalled = (occ > 0) && !out_ready;
            h_instr = out_instruction; h_pc = out_pc; h_flags = flags_now(); h_ill = illegal;
            step();
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || out_instruction !== h_instr || out_pc !== h_pc
                             || flags_now() !== h_flags || illegal !== h_ill) begin errors++;
                    $display("[TB] FAIL rand_hold[%0d] got v=%b %h/%h/%b want v=1 %h/%h/%b",
                             c, out_valid, out_instruction, out_pc, flags_now(), h_instr, h_pc, h_flags); end
            end
            if (fr) begin void'(q.pop_front()); occ--; end
            if (acc) begin q.push_back({w, pc_ctr}); occ++; pc_ctr += 32'd4; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL rand_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
